// File: rtl/kronos_mem_arb.sv
// Arbiter sharing one memory port between the core fetch and load/store ports.
// Data side wins contention until the fetch side has lost STARVE_LIMIT times in a row.
module kronos_mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  localparam int unsigned CNT_W = (STARVE_LIMIT != 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam bit FAIR_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wr_data_q, mem_wr_data_d;
  logic [3:0]       mem_mask_q, mem_mask_d;
  logic             mem_wr_en_q, mem_wr_en_d;
  logic             force_instr;

  assign force_instr = FAIR_EN && (starve_cnt_q == CNT_MAX);

  // Arbitration and command capture; command fields only change on the IDLE exit edge.
  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_mask_d    = mem_mask_q;
    mem_wr_en_d   = mem_wr_en_q;
    case (state_q)
      IDLE: begin
        if (data_req && !(instr_req && force_instr)) begin
          state_d       = GNT_D;
          mem_addr_d    = data_addr;
          mem_wr_data_d = data_wr_data;
          mem_mask_d    = data_mask;
          mem_wr_en_d   = data_wr_en;
          if (instr_req && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (instr_req) begin
          state_d       = GNT_I;
          mem_addr_d    = instr_addr;
          mem_wr_data_d = 32'h0;
          mem_mask_d    = 4'hF;
          mem_wr_en_d   = 1'b0;
          starve_cnt_d  = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_mask_q    <= '0;
      mem_wr_en_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_mask_q    <= mem_mask_d;
      mem_wr_en_q   <= mem_wr_en_d;
    end
  end

  // Acks complete in the same cycle as mem_ack; read data is shared by both sides.
  assign mem_req      = (state_q != IDLE);
  assign instr_ack    = (state_q == GNT_I) && mem_ack;
  assign data_ack     = (state_q == GNT_D) && mem_ack;
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;
  assign mem_addr     = mem_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign mem_mask     = mem_mask_q;
  assign mem_wr_en    = mem_wr_en_q;

endmodule

// File: tb/tb_kronos_mem_arb.sv
// Directed bench for kronos_mem_arb: fetch, store, contention fairness, stability, reset.
module tb_kronos_mem_arb;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] instr_addr, data_addr, data_wr_data, mem_rd_data;
  logic        instr_req, data_req, data_wr_en, mem_ack, mem_ack_z;
  logic [3:0]  data_mask;

  logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data;
  logic        instr_ack, data_ack, mem_wr_en, mem_req;
  logic [3:0]  mem_mask;

  logic [31:0] z_instr_data, z_data_rd_data, z_mem_addr, z_mem_wr_data;
  logic        z_instr_ack, z_data_ack, z_mem_wr_en, z_mem_req;
  logic [3:0]  z_mem_mask;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  kronos_mem_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data), .instr_ack(instr_ack),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_rd_data(data_rd_data), .data_ack(data_ack),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask), .mem_wr_en(mem_wr_en),
    .mem_req(mem_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
  );

  kronos_mem_arb #(.STARVE_LIMIT(0)) dut_z (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(z_instr_data), .instr_ack(z_instr_ack),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_rd_data(z_data_rd_data), .data_ack(z_data_ack),
    .mem_addr(z_mem_addr), .mem_wr_data(z_mem_wr_data), .mem_mask(z_mem_mask), .mem_wr_en(z_mem_wr_en),
    .mem_req(z_mem_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp_is_d;
  int         exp_cnt [6];
  int         z_grants;

  initial begin
    rstz = 1'b0; instr_req = 1'b0; data_req = 1'b0; instr_addr = '0; data_addr = '0;
    data_wr_data = '0; data_mask = '0; data_wr_en = 1'b0; mem_rd_data = '0;
    mem_ack = 1'b0; mem_ack_z = 1'b0;
    #12;
    chk("rst_mem_req",   32'(mem_req), 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wr_data, 32'h0);
    chk("rst_mem_mask",  32'(mem_mask), 32'h0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_acks",      32'({instr_ack, data_ack}), 32'h0);
    chk("rst_starve",    32'(dut.starve_cnt_q), 32'h0);
    rstz = 1'b1;

    // Single fetch with mem_ack three cycles after mem_req; address change must not leak.
    cyc(); instr_req = 1'b1; instr_addr = 32'h100; #3;
    chk("f_idle_req", 32'(mem_req), 32'h0);
    cyc(); #3;
    chk("f_req",   32'(mem_req), 32'h1);
    chk("f_addr",  mem_addr, 32'h100);
    chk("f_wr_en", 32'(mem_wr_en), 32'h0);
    chk("f_mask",  32'(mem_mask), 32'hF);
    chk("f_wdata", mem_wr_data, 32'h0);
    chk("f_noack", 32'(instr_ack), 32'h0);
    cyc(); instr_addr = 32'h200; #3;
    chk("f_stable1", mem_addr, 32'h100);
    cyc(); #3;
    chk("f_stable2", mem_addr, 32'h100);
    chk("f_noack2",  32'(instr_ack), 32'h0);
    cyc(); mem_ack = 1'b1; mem_rd_data = 32'h13; #3;
    chk("f_ack",     32'(instr_ack), 32'h1);
    chk("f_dack",    32'(data_ack), 32'h0);
    chk("f_data",    instr_data, 32'h13);
    chk("f_dpass",   data_rd_data, 32'h13);
    chk("f_stable3", mem_addr, 32'h100);
    cyc(); mem_ack = 1'b0; instr_req = 1'b0; #3;
    chk("f_done_req", 32'(mem_req), 32'h0);
    chk("f_done_ack", 32'(instr_ack), 32'h0);

    // Store with immediate mem_ack.
    cyc(); data_req = 1'b1; data_addr = 32'h2004; data_wr_data = 32'hDEADBEEF;
    data_mask = 4'b0011; data_wr_en = 1'b1; #3;
    chk("s_idle_req", 32'(mem_req), 32'h0);
    cyc(); mem_ack = 1'b1; #3;
    chk("s_req",   32'(mem_req), 32'h1);
    chk("s_addr",  mem_addr, 32'h2004);
    chk("s_wdata", mem_wr_data, 32'hDEADBEEF);
    chk("s_mask",  32'(mem_mask), 32'h3);
    chk("s_wr_en", 32'(mem_wr_en), 32'h1);
    chk("s_ack",   32'(data_ack), 32'h1);
    chk("s_iack",  32'(instr_ack), 32'h0);
    cyc(); mem_ack = 1'b0; data_req = 1'b0; #3;
    chk("s_done_req", 32'(mem_req), 32'h0);
    chk("s_done_ack", 32'(data_ack), 32'h0);

    // Spurious mem_ack in IDLE.
    cyc(); mem_ack = 1'b1; #3;
    chk("sp_acks", 32'({instr_ack, data_ack}), 32'h0);
    cyc(); mem_ack = 1'b0; #3;
    chk("sp_req", 32'(mem_req), 32'h0);

    // Contention: D,D,D,D,I,D with starve count 1,2,3,4,0,0.
    exp_is_d = 6'b101111;
    exp_cnt  = '{1, 2, 3, 4, 0, 0};
    cyc(); instr_req = 1'b1; instr_addr = 32'h300; data_req = 1'b1; data_addr = 32'h400;
    data_wr_en = 1'b0; data_mask = 4'hF; #3;
    for (int k = 0; k < 6; k++) begin
      cyc(); mem_ack = 1'b1; #3;
      chk($sformatf("c%0d_req", k),   32'(mem_req), 32'h1);
      chk($sformatf("c%0d_addr", k),  mem_addr, exp_is_d[k] ? 32'h400 : 32'h300);
      chk($sformatf("c%0d_dack", k),  32'(data_ack), 32'(exp_is_d[k]));
      chk($sformatf("c%0d_iack", k),  32'(instr_ack), 32'(!exp_is_d[k]));
      chk($sformatf("c%0d_cnt", k),   32'(dut.starve_cnt_q), 32'(exp_cnt[k]));
      cyc(); mem_ack = 1'b0;
      if (!exp_is_d[k]) instr_req = 1'b0;
      if (k == 5) data_req = 1'b0;
      #3;
      chk($sformatf("c%0d_bubble", k), 32'(mem_req), 32'h0);
    end

    // Reset mid GNT_D with mem_ack withheld.
    cyc(); data_req = 1'b1; data_addr = 32'h500; data_wr_en = 1'b1; #3;
    chk("r_idle_req", 32'(mem_req), 32'h0);
    cyc(); #3;
    chk("r_req",  32'(mem_req), 32'h1);
    chk("r_noack", 32'(data_ack), 32'h0);
    #1 rstz = 1'b0; #1;
    chk("r_req_drop", 32'(mem_req), 32'h0);
    chk("r_addr",     mem_addr, 32'h0);
    chk("r_wr_en",    32'(mem_wr_en), 32'h0);
    chk("r_dack",     32'(data_ack), 32'h0);
    data_req = 1'b0;
    cyc(); rstz = 1'b1;
    cyc(); mem_ack = 1'b1; #3;
    chk("r_spur_ack", 32'({instr_ack, data_ack}), 32'h0);
    chk("r_spur_req", 32'(mem_req), 32'h0);
    cyc(); mem_ack = 1'b0; #3;
    chk("r_after_req", 32'(mem_req), 32'h0);

    // STARVE_LIMIT=0: data always wins while both are pending.
    z_grants = 0;
    cyc(); instr_req = 1'b1; instr_addr = 32'h700; data_req = 1'b1; data_addr = 32'h600;
    mem_ack_z = 1'b1; #3;
    for (int i = 0; i < 10; i++) begin
      cyc(); #3;
      if (z_mem_req) begin
        z_grants++;
        chk($sformatf("z%0d_addr", i), z_mem_addr, 32'h600);
      end
      chk($sformatf("z%0d_iack", i), 32'(z_instr_ack), 32'h0);
      chk($sformatf("z%0d_dack", i), 32'(z_data_ack), 32'(z_mem_req));
      chk($sformatf("z%0d_cnt", i),  32'(dut_z.starve_cnt_q), 32'h0);
    end
    chk("z_grants", 32'(z_grants), 32'd5);
    instr_req = 1'b0; data_req = 1'b0; mem_ack_z = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kronos_mem_arb.md
KRONOS_MEM_ARB -- requirements
Module: kronos_mem_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive contested data grants before instr is forced; 0 disables the fairness override (pure data priority).
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rstz  input  1  reset; asynchronous, active-low.
REQ-004 instr_addr  input  32  fetch address from the core fetch port.
REQ-005 instr_req  input  1  fetch request; held high until instr_ack.
REQ-006 instr_data  output  32  fetch read data; valid when instr_ack=1.
REQ-007 instr_ack  output  1  fetch completion; single-cycle pulse.
REQ-008 data_addr  input  32  load/store address from the core data port.
REQ-009 data_wr_data  input  32  store data.
REQ-010 data_mask  input  4  byte enables.
REQ-011 data_wr_en  input  1  1=store, 0=load.
REQ-012 data_req  input  1  load/store request; held high until data_ack.
REQ-013 data_rd_data  output  32  load data; valid when data_ack=1.
REQ-014 data_ack  output  1  load/store completion; single-cycle pulse.
REQ-015 mem_addr, mem_wr_data, mem_mask, mem_wr_en  output  32/32/4/1  shared memory port command fields.
REQ-016 mem_req  output  1  shared port request.
REQ-017 mem_rd_data  input  32  shared port read data.
REQ-018 mem_ack  input  1  shared port completion pulse.

Function
REQ-019 The block SHALL implement states IDLE, GNT_I, GNT_D; mem_req SHALL equal (state != IDLE).
REQ-020 In IDLE, with only instr_req high, the block SHALL enter GNT_I next cycle; with only data_req high, GNT_D.
REQ-021 In IDLE, with both requests high, the block SHALL enter GNT_D unless STARVE_LIMIT>0 and starve_cnt==STARVE_LIMIT, in which case GNT_I.
REQ-022 On the IDLE exit edge, the block SHALL register the granted requester's address, write data, mask and wr_en into mem_*; instr grants SHALL drive mem_wr_en=0, mem_mask=4'hF, mem_wr_data=0.
REQ-023 mem_* command fields SHALL remain stable throughout a granted state regardless of requester input changes.
REQ-024 In GNT_x, while mem_ack=0, the block SHALL hold state and mem_req=1.
REQ-025 In GNT_x, when mem_ack=1, the block SHALL assert the matching ack combinationally in that cycle and return to IDLE on the next edge (one idle bubble between transactions).
REQ-026 instr_data and data_rd_data SHALL both pass mem_rd_data through combinationally; only the granted side's ack is asserted.
REQ-027 instr_ack and data_ack SHALL never be high together, and SHALL be 0 whenever state is IDLE or mem_ack=0.
REQ-028 starve_cnt (width clog2(STARVE_LIMIT+1), min 1 bit) SHALL increment, saturating at STARVE_LIMIT, on each IDLE->GNT_D transition taken while instr_req=1.
REQ-029 starve_cnt SHALL clear on every IDLE->GNT_I transition and SHALL hold otherwise.
REQ-030 A request arriving while the other side is granted SHALL wait; it is arbitrated in the following IDLE cycle.
REQ-031 Minimum latency: req high in cycle N (state IDLE) -> mem_req high in N+1 -> ack in N+1 if mem_ack=1 in N+1.
REQ-032 mem_ack received in IDLE SHALL be ignored (no ack, no state change).

Reset
REQ-033 While rstz=0, the block SHALL force state=IDLE, starve_cnt=0, mem_req=0, mem_addr=0, mem_wr_data=0, mem_mask=0, mem_wr_en=0, instr_ack=0, data_ack=0, asynchronously.
REQ-034 Reset asserted mid-transaction SHALL abandon it without issuing an ack; after release, arbitration restarts from IDLE.

Verification
REQ-035 Single fetch: instr_req=1, instr_addr=0x100, mem_ack 3 cycles after mem_req with mem_rd_data=0x00000013 -> mem_addr=0x100, mem_wr_en=0, one instr_ack pulse, instr_data=0x13.
REQ-036 Store: data_req=1, addr=0x2004, wr_data=0xDEADBEEF, mask=4'b0011, wr_en=1, mem_ack immediate -> mem fields match exactly, data_ack in first mem_req cycle, mem_req low next cycle.
REQ-037 Contention: both requests raised same cycle, data_req re-raised after each ack for 6 transactions, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D; starve_cnt 0->4->0.
REQ-038 STARVE_LIMIT=0, both requests continuously high -> instr never granted while data_req pending; starve_cnt stays 0.
REQ-039 Stability: change instr_addr from 0x100 to 0x200 during GNT_I wait -> mem_addr stays 0x100 until ack.
REQ-040 Reset mid-GNT_D (mem_ack withheld) -> mem_req drops immediately at rstz=0, no data_ack, spurious mem_ack in IDLE ignored after release.
